// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel position, active windows, line length and lock from hsync/vsync.
// Define VGA_RX_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing_rx #(
  parameter int H_SYNCPULSE = 96,
  parameter int H_BPORCH    = 48,
  parameter int H_DISPLAY   = 640,
  parameter int H_FPORCH    = 16,
  parameter int H_SYNC      = 800,
  parameter int V_SYNCPULSE = 2,
  parameter int V_BPORCH    = 33,
  parameter int V_DISPLAY   = 480,
  parameter int V_SYNC      = 525,
  parameter int LOCK_LINES  = 4,
  parameter int MISS_LINES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        h_active,
  output logic        v_active,
  output logic        pix_valid,
  output logic [11:0] line_len,
  output logic        locked,
  output logic        sync_err
`ifdef VGA_RX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_ON   = H_SYNCPULSE + H_BPORCH;
  localparam int H_OFF  = H_ON + H_DISPLAY;
  localparam int V_ON   = V_SYNCPULSE + V_BPORCH;
  localparam int V_OFF  = V_ON + V_DISPLAY;
  localparam int H_LOST = 2 * H_SYNC;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  if (H_OFF + H_FPORCH != H_SYNC) begin : g_hchk
    $error("vga_timing_rx: horizontal timing does not add up to H_SYNC");
  end
  if (V_OFF > V_SYNC) begin : g_vchk
    $error("vga_timing_rx: vertical windows exceed V_SYNC");
  end

  logic        hs_d;
  logic        vs_d;
  logic        hrise;
  logic        vrise;
  logic [11:0] hcnt;
  logic [11:0] hnext;
  logic [9:0]  vcnt;
  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [7:0]  good;
  logic [7:0]  good_n;
  logic [7:0]  miss;
  logic [7:0]  miss_n;
  logic        err_n;
  logic        line_ok;
  logic        lost;
  logic        hact_c;
  logic        vact_c;

  assign hrise   = hsync_in & ~hs_d;
  assign vrise   = vsync_in & ~vs_d;
  // hnext doubles as the saturated length of the line ending at hrise
  assign hnext   = (hcnt == 12'hfff) ? hcnt : hcnt + 12'd1;
  assign line_ok = (hnext == 12'(H_SYNC));
  assign lost    = ~hrise & (hcnt == 12'(H_LOST));
  assign hact_c  = (hcnt >= 12'(H_ON)) && (hcnt < 12'(H_OFF));
  assign vact_c  = (vcnt >= 10'(V_ON)) && (vcnt < 10'(V_OFF));

  always_comb begin
    state_n = state;
    good_n  = good;
    miss_n  = miss;
    err_n   = 1'b0;
    if (lost) begin
      state_n = ST_SEARCH;
    end else if (hrise) begin
      unique case (1'b1)
        (state == ST_VERIFY): begin
          if (line_ok) begin
            good_n = good + 8'd1;
            if (good_n == 8'(LOCK_LINES)) begin
              state_n = ST_LOCKED;
              miss_n  = '0;
            end
          end else begin
            good_n = '0;
            err_n  = 1'b1;
          end
        end
        (state == ST_LOCKED): begin
          if (line_ok) begin
            miss_n = '0;
          end else begin
            err_n  = 1'b1;
            miss_n = miss + 8'd1;
            if (miss_n == 8'(MISS_LINES)) begin
              state_n = ST_SEARCH;
            end
          end
        end
        default: begin
          state_n = ST_VERIFY;
          good_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      state     <= ST_SEARCH;
      good      <= '0;
      miss      <= '0;
      x         <= '0;
      y         <= '0;
      h_active  <= 1'b0;
      v_active  <= 1'b0;
      pix_valid <= 1'b0;
      line_len  <= '0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      hs_d     <= hsync_in;
      vs_d     <= vsync_in;
      hcnt     <= hrise ? 12'd0 : hnext;
      if (vrise) begin
        vcnt <= '0;
      end else if (hrise && vcnt != 10'h3ff) begin
        vcnt <= vcnt + 10'd1;
      end
      if (hrise) begin
        line_len <= hnext;
      end
      state     <= state_n;
      good      <= good_n;
      miss      <= miss_n;
      sync_err  <= err_n;
      locked    <= (state_n == ST_LOCKED);
      h_active  <= hact_c;
      v_active  <= vact_c;
      x         <= hact_c ? 10'(hcnt - 12'(H_ON)) : 10'd0;
      y         <= vact_c ? (vcnt - 10'(V_ON)) : 10'd0;
      pix_valid <= hact_c & vact_c & (state_n == ST_LOCKED);
    end
  end

`ifdef VGA_RX_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (vrise && locked) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed sync streams checked against a cycle-stamp model every cycle.
// Vertical timing is shortened (20 lines) so several full frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_rx;

  localparam int HS     = 96;
  localparam int H_ON   = 144;
  localparam int H_OFF  = 784;
  localparam int HT     = 800;
  localparam int V_ON   = 5;
  localparam int V_OFF  = 15;
  localparam int LOCK_N = 4;
  localparam int MISS_N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        h_active;
  logic        v_active;
  logic        pix_valid;
  logic [11:0] line_len;
  logic        locked;
  logic        sync_err;
`ifdef VGA_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int total = 0;
  int bad = 0;
  int nprint = 0;
  int cur_line = 0;
  int cur_pos = 0;
  int pv_cnt = 0;
  int pv_line = -1;
  int pv_pos = -1;
  int pv_fx = -1;
  int pv_fy = -1;
  int pv_lx = -1;
  int pv_ly = -1;
  int err_seen = 0;

  vga_timing_rx #(
    .V_BPORCH (3),
    .V_DISPLAY(10),
    .V_SYNC   (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .x        (x),
    .y        (y),
    .h_active (h_active),
    .v_active (v_active),
    .pix_valid(pix_valid),
    .line_len (line_len),
    .locked   (locked),
    .sync_err (sync_err)
`ifdef VGA_RX_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // model: position is the distance from the last hsync rise stamp
  longint m_t = 0;
  longint m_hr_t = 0;
  longint m_lines = 0;
  bit m_on = 0, m_hs = 0, m_vs = 0, m_meas = 0, m_lk = 0;
  int m_good = 0, m_bad = 0;
  int e_x = 0, e_y = 0, e_len = 0, e_fc = 0;
  bit e_ha = 0, e_va = 0, e_pv = 0, e_lk = 0, e_err = 0;

  always @(posedge clk) begin : model_p
    int hc;
    int vc;
    bit hr;
    bit vr;
    bit ok;
    bit was_lk;
    m_t++;
    if (!rst_n) begin
      m_on = 1; m_hr_t = m_t; m_lines = 0;
      m_hs = 0; m_vs = 0; m_meas = 0; m_lk = 0;
      m_good = 0; m_bad = 0;
      e_x = 0; e_y = 0; e_len = 0; e_fc = 0;
      e_ha = 0; e_va = 0; e_pv = 0; e_lk = 0; e_err = 0;
    end else begin
      hr = hsync_in && !m_hs;
      vr = vsync_in && !m_vs;
      hc = (m_t - m_hr_t - 1 > 4095) ? 4095 : int'(m_t - m_hr_t - 1);
      vc = (m_lines > 1023) ? 1023 : int'(m_lines);
      e_ha = (hc >= H_ON) && (hc < H_OFF);
      e_va = (vc >= V_ON) && (vc < V_OFF);
      e_x = e_ha ? hc - H_ON : 0;
      e_y = e_va ? vc - V_ON : 0;
      e_err = 0;
      was_lk = m_lk;
      if (!hr && hc == 2 * HT) begin
        m_lk = 0; m_meas = 0;
      end else if (hr) begin
        e_len = (hc + 1 > 4095) ? 4095 : hc + 1;
        ok = (hc + 1 == HT);
        if (!m_meas) begin
          m_meas = 1; m_good = 0;
        end else if (!m_lk) begin
          if (ok) begin
            m_good++;
            if (m_good == LOCK_N) begin m_lk = 1; m_bad = 0; end
          end else begin
            m_good = 0; e_err = 1;
          end
        end else if (ok) begin
          m_bad = 0;
        end else begin
          e_err = 1; m_bad++;
          if (m_bad == MISS_N) begin m_lk = 0; m_meas = 0; end
        end
      end
      e_lk = m_lk;
      e_pv = e_ha && e_va && m_lk;
      if (vr && was_lk) e_fc = (e_fc + 1) % 65536;
      if (hr) m_hr_t = m_t;
      if (vr) m_lines = 0;
      else if (hr) m_lines++;
      m_hs = hsync_in;
      m_vs = vsync_in;
    end
  end

  always @(posedge clk) begin : cmp_p
    logic [36:0] act;
    logic [36:0] exp;
    #3;
    if (m_on) begin
      act = {x, y, h_active, v_active, pix_valid, line_len, locked, sync_err};
      exp = {10'(e_x), 10'(e_y), e_ha, e_va, e_pv, 12'(e_len), e_lk, e_err};
      total++;
      if (act !== exp) begin
        bad++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL cycle_cmp line=%0d pos=%0d got x=%0d y=%0d ha=%b va=%b pv=%b len=%0d lk=%b err=%b want x=%0d y=%0d ha=%b va=%b pv=%b len=%0d lk=%b err=%b",
                   cur_line, cur_pos, x, y, h_active, v_active, pix_valid, line_len, locked, sync_err,
                   e_x, e_y, e_ha, e_va, e_pv, e_len, e_lk, e_err);
        end
      end
`ifdef VGA_RX_FRAME_CNT_EN
      total++;
      if (frame_cnt !== 16'(e_fc)) begin
        bad++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, e_fc);
        end
      end
`endif
      if (pix_valid === 1'b1) begin
        if (pv_cnt == 0) begin
          pv_line = cur_line; pv_pos = cur_pos;
          pv_fx = int'(x); pv_fy = int'(y);
        end
        pv_cnt++;
        pv_lx = int'(x); pv_ly = int'(y);
      end
      if (sync_err === 1'b1) err_seen++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic drive(input bit h, input bit v);
    hsync_in = h;
    vsync_in = v;
    @(negedge clk);
  endtask

  task automatic seg(input int ln, input int a, input int b);
    cur_line = ln;
    for (int p = a; p < b; p++) begin
      cur_pos = p;
      drive(p < HS, ln >= 0 && ln < 2);
    end
  endtask

  task automatic lines(input int a, input int b);
    for (int l = a; l < b; l++) seg(l, 0, HT);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    cur_line = -1;
    repeat (3) drive(1'b0, 1'b0);
    chk("reset_outs", 64'({x, y, h_active, v_active, pix_valid, line_len, locked, sync_err}), 64'd0);
    rst_n = 1'b1;

    // frame 1: lock, vrise+hrise together, full active window
    pv_cnt = 0;
    seg(0, 0, HT);
    seg(1, 0, 400);
    chk("vrise_hrise_y", 64'(y), 64'd0);
    chk("vrise_hrise_vact", 64'(v_active), 64'd0);
    seg(1, 400, HT);
    lines(2, 4);
    chk("prelock", 64'(locked), 64'd0);
    seg(4, 0, 1);
    chk("lock_5th_hrise", 64'(locked), 64'd1);
    chk("line_len_800", 64'(line_len), 64'd800);
    seg(4, 1, HT);
    lines(5, 20);
    chk("pv_first_line", 64'(pv_line), 64'd5);
    chk("pv_first_pos", 64'(pv_pos), 64'd145);
    chk("pv_first_x", 64'(pv_fx), 64'd0);
    chk("pv_first_y", 64'(pv_fy), 64'd0);
    chk("pv_last_x", 64'(pv_lx), 64'd639);
    chk("pv_last_y", 64'(pv_ly), 64'd9);
    chk("pv_count", 64'(pv_cnt), 64'd6400);
    chk("no_err_frame1", 64'(err_seen), 64'd0);

    // frame 2: short lines
    lines(0, 3);
    seg(3, 0, HT - 1);
    seg(4, 0, 1);
    chk("short_err", 64'(sync_err), 64'd1);
    chk("short_len", 64'(line_len), 64'd799);
    chk("short_still_locked", 64'(locked), 64'd1);
    seg(4, 1, HT);
    seg(5, 0, HT - 1);
    seg(6, 0, HT - 1);
    seg(7, 0, 1);
    chk("two_short_unlock", 64'(locked), 64'd0);
    chk("err_count", 64'(err_seen), 64'd3);
    seg(7, 1, HT);
    lines(8, 20);
    chk("relock_frame2", 64'(locked), 64'd1);

    // hsync lost
    cur_line = -1;
    repeat (1700) drive(1'b0, 1'b0);
    chk("lost_unlock", 64'(locked), 64'd0);
    chk("lost_no_err", 64'(err_seen), 64'd3);
    lines(0, 4);
    seg(4, 0, 1);
    chk("relock_after_lost", 64'(locked), 64'd1);
    seg(4, 1, HT);
    lines(5, 8);

    // reset mid-line at x=300
    seg(8, 0, 446);
    chk("mid_x", 64'(x), 64'd300);
    chk("mid_y", 64'(y), 64'd3);
    chk("mid_pv", 64'(pix_valid), 64'd1);
`ifdef VGA_RX_FRAME_CNT_EN
    chk("fc_before_rst", 64'(frame_cnt), 64'd1);
`endif
    rst_n = 1'b0;
    cur_pos = 446;
    drive(1'b0, 1'b0);
    chk("midrst_outs", 64'({x, y, h_active, v_active, pix_valid, line_len, locked, sync_err}), 64'd0);
`ifdef VGA_RX_FRAME_CNT_EN
    chk("midrst_fc", 64'(frame_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    seg(8, 447, HT);
    lines(9, 13);
    seg(13, 0, 1);
    chk("relock_after_rst", 64'(locked), 64'd1);
    seg(13, 1, HT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
